// File: rtl/namuru_accum_status_if.sv
// ============================================================================
// Module   : namuru_accum_status_if
// Brief    : Strobe/status bundle between the CPU-side logic and the
//            accumulator status block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface namuru_accum_status_if #(
    parameter int NCH = 12,
    parameter int TW  = 16
);
    logic             accum_enable_i;
    logic             tic_enable_i;
    logic [NCH-1:0]   dump_i;
    logic [NCH-1:0]   ch_rd_i;
    logic             status_rd_i;
    logic             irq_en_we_i;
    logic [1:0]       irq_en_wdata_i;

    logic [NCH-1:0]   new_data_o;
    logic [NCH-1:0]   snap_new_data_o;
    logic [NCH-1:0]   missed_o;
    logic [1:0]       status_o;
    logic [1:0]       irq_en_o;
    logic             irq_o;
    logic [TW-1:0]    tic_cnt_o;

    modport slave (
        input  accum_enable_i, tic_enable_i, dump_i, ch_rd_i,
               status_rd_i, irq_en_we_i, irq_en_wdata_i,
        output new_data_o, snap_new_data_o, missed_o, status_o,
               irq_en_o, irq_o, tic_cnt_o
    );

    modport master (
        output accum_enable_i, tic_enable_i, dump_i, ch_rd_i,
               status_rd_i, irq_en_we_i, irq_en_wdata_i,
        input  new_data_o, snap_new_data_o, missed_o, status_o,
               irq_en_o, irq_o, tic_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/namuru_accum_status.sv
// ============================================================================
// Module   : namuru_accum_status
// Brief    : Per-channel fresh-data / overrun flags, TIC and ACCUM_INT status
//            flags, TIC counter and level interrupt. Overrun logic is built
//            only when NAMURU_ACCUM_MISSED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module namuru_accum_status #(
    parameter int NCH = 12,
    parameter int TW  = 16
) (
    input  wire                          clk,
    input  wire                          rstn,
    namuru_accum_status_if.slave         bus
);

    logic [NCH-1:0] new_data_q,  new_data_d;
    logic [NCH-1:0] snap_q,      snap_d;
    logic [1:0]     status_q,    status_d;
    logic [1:0]     irq_en_q,    irq_en_d;
    logic           irq_q,       irq_d;
    logic [TW-1:0]  tic_cnt_q,   tic_cnt_d;

    // A dump in the same cycle as a channel read still leaves the data fresh.
    always_comb begin
        new_data_d = (new_data_q & ~bus.ch_rd_i) | bus.dump_i;
        snap_d     = bus.accum_enable_i ? new_data_d : snap_q;

        status_d[0] = bus.accum_enable_i | (status_q[0] & ~bus.status_rd_i);
        status_d[1] = bus.tic_enable_i   | (status_q[1] & ~bus.status_rd_i);

        tic_cnt_d = tic_cnt_q + {{(TW-1){1'b0}}, bus.tic_enable_i};
        irq_en_d  = bus.irq_en_we_i ? bus.irq_en_wdata_i : irq_en_q;
        irq_d     = |(status_d & irq_en_d);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            new_data_q <= '0;
            snap_q     <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            tic_cnt_q  <= '0;
        end else begin
            new_data_q <= new_data_d;
            snap_q     <= snap_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            tic_cnt_q  <= tic_cnt_d;
        end
    end

`ifdef NAMURU_ACCUM_MISSED_EN
    logic [NCH-1:0] missed_q, missed_d;

    // Overrun: a dump lands on still-unread data; set beats the status-read clear.
    always_comb begin
        missed_d = (missed_q & ~{NCH{bus.status_rd_i}})
                 | (bus.dump_i & new_data_q & ~bus.ch_rd_i);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            missed_q <= '0;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign bus.missed_o = missed_q;
`else
    assign bus.missed_o = '0;
`endif

    assign bus.new_data_o      = new_data_q;
    assign bus.snap_new_data_o = snap_q;
    assign bus.status_o        = status_q;
    assign bus.irq_en_o        = irq_en_q;
    assign bus.irq_o           = irq_q;
    assign bus.tic_cnt_o       = tic_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_namuru_accum_status.sv
// ============================================================================
// Module   : tb_namuru_accum_status
// Brief    : Self-checking bench: directed vector table, TIC wrap sequence and
//            randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_namuru_accum_status;
    localparam int NCH = 12;
    localparam int TW  = 16;
`ifdef NAMURU_ACCUM_MISSED_EN
    localparam bit MISSED_ON = 1'b1;
`else
    localparam bit MISSED_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    namuru_accum_status_if #(.NCH(NCH), .TW(TW)) bus ();
    namuru_accum_status #(.NCH(NCH), .TW(TW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct packed {
        logic           rstn;
        logic           acc;
        logic           tic;
        logic [NCH-1:0] dump;
        logic [NCH-1:0] ch_rd;
        logic           srd;
        logic           we;
        logic [1:0]     wd;
        logic [NCH-1:0] e_new;
        logic [NCH-1:0] e_missed;
        logic [NCH-1:0] e_snap;
        logic [1:0]     e_status;
        logic [1:0]     e_en;
        logic           e_irq;
        logic [TW-1:0]  e_cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [NCH-1:0] m_new, m_missed, m_snap;
    logic           m_acc, m_tic, m_irq;
    logic [1:0]     m_en;
    int             m_cnt;

    function automatic vec_t mk(input logic r, input logic a, input logic t,
                                input logic [NCH-1:0] d, input logic [NCH-1:0] c,
                                input logic s, input logic w, input logic [1:0] wd,
                                input logic [NCH-1:0] en, input logic [NCH-1:0] em,
                                input logic [NCH-1:0] es, input logic [1:0] est,
                                input logic [1:0] een, input logic ei,
                                input logic [TW-1:0] ec);
        vec_t v;
        v.rstn = r; v.acc = a; v.tic = t; v.dump = d; v.ch_rd = c;
        v.srd = s; v.we = w; v.wd = wd;
        v.e_new = en; v.e_missed = em; v.e_snap = es; v.e_status = est;
        v.e_en = een; v.e_irq = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model(input vec_t v);
        logic old;
        if (!v.rstn) begin
            m_new = '0; m_missed = '0; m_snap = '0;
            m_acc = 0; m_tic = 0; m_irq = 0; m_en = '0; m_cnt = 0;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            old = m_new[i];
            if (v.dump[i])       m_new[i] = 1'b1;
            else if (v.ch_rd[i]) m_new[i] = 1'b0;
            if (MISSED_ON && v.dump[i] && old && !v.ch_rd[i]) m_missed[i] = 1'b1;
            else if (v.srd)                                  m_missed[i] = 1'b0;
        end
        if (v.acc) m_snap = m_new;
        if (v.acc) m_acc = 1'b1; else if (v.srd) m_acc = 1'b0;
        if (v.tic) m_tic = 1'b1; else if (v.srd) m_tic = 1'b0;
        if (v.tic) m_cnt = (m_cnt + 1) % (1 << TW);
        if (v.we)  m_en = v.wd;
        m_irq = (m_acc && m_en[0]) || (m_tic && m_en[1]);
    endtask

    task automatic apply(input vec_t v);
        rstn                = v.rstn;
        bus.accum_enable_i  = v.acc;
        bus.tic_enable_i    = v.tic;
        bus.dump_i          = v.dump;
        bus.ch_rd_i         = v.ch_rd;
        bus.status_rd_i     = v.srd;
        bus.irq_en_we_i     = v.we;
        bus.irq_en_wdata_i  = v.wd;
        @(posedge clk);
        model(v);
        #1;
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d new_data", cyc), 64'(bus.new_data_o), 64'(m_new));
        check($sformatf("rnd%0d missed", cyc), 64'(bus.missed_o), 64'(m_missed));
        check($sformatf("rnd%0d snap", cyc), 64'(bus.snap_new_data_o), 64'(m_snap));
        check($sformatf("rnd%0d status", cyc), 64'(bus.status_o), 64'({m_tic, m_acc}));
        check($sformatf("rnd%0d irq_en", cyc), 64'(bus.irq_en_o), 64'(m_en));
        check($sformatf("rnd%0d irq", cyc), 64'(bus.irq_o), 64'(m_irq));
        check($sformatf("rnd%0d tic_cnt", cyc), 64'(bus.tic_cnt_o), 64'(m_cnt));
    endtask

    localparam int NV = 19;
    vec_t tbl [NV];
    localparam logic [NCH-1:0] Z = '0;

    initial begin
        vec_t v;
        vec_t idle;
        idle = mk(1, 0, 0, Z, Z, 0, 0, 2'b00, Z, Z, Z, 2'b00, 2'b00, 0, '0);

        //           rst acc tic dump     ch_rd    srd we wd     new      missed   snap     st     en     irq cnt
        tbl[0]  = mk(0, 0, 0, Z,       Z,       0, 0, 2'b00, Z,       Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[1]  = mk(1, 0, 0, 12'h008, Z,       0, 0, 2'b00, 12'h008, Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[2]  = mk(1, 0, 0, Z,       12'h008, 0, 0, 2'b00, Z,       Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[3]  = mk(1, 0, 0, 12'h020, Z,       0, 0, 2'b00, 12'h020, Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[4]  = mk(1, 0, 0, 12'h020, Z,       0, 0, 2'b00, 12'h020, 12'h020, Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[5]  = mk(1, 0, 0, Z,       12'h020, 0, 0, 2'b00, Z,       12'h020, Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[6]  = mk(1, 0, 0, Z,       Z,       1, 0, 2'b00, Z,       Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[7]  = mk(1, 0, 0, 12'h004, 12'h004, 0, 0, 2'b00, 12'h004, Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[8]  = mk(1, 0, 0, Z,       Z,       0, 1, 2'b01, 12'h004, Z,       Z,       2'b00, 2'b01, 0, 16'd0);
        tbl[9]  = mk(1, 1, 0, Z,       Z,       0, 0, 2'b00, 12'h004, Z,       12'h004, 2'b01, 2'b01, 1, 16'd0);
        tbl[10] = mk(1, 1, 0, Z,       Z,       1, 0, 2'b00, 12'h004, Z,       12'h004, 2'b01, 2'b01, 1, 16'd0);
        tbl[11] = mk(1, 0, 0, Z,       Z,       1, 0, 2'b00, 12'h004, Z,       12'h004, 2'b00, 2'b01, 0, 16'd0);
        tbl[12] = mk(1, 1, 0, 12'h001, Z,       0, 0, 2'b00, 12'h005, Z,       12'h005, 2'b01, 2'b01, 1, 16'd0);
        tbl[13] = mk(1, 0, 0, Z,       12'h001, 0, 0, 2'b00, 12'h004, Z,       12'h005, 2'b01, 2'b01, 1, 16'd0);
        tbl[14] = mk(1, 0, 1, Z,       Z,       0, 0, 2'b00, 12'h004, Z,       12'h005, 2'b11, 2'b01, 1, 16'd1);
        tbl[15] = mk(1, 0, 0, Z,       Z,       0, 1, 2'b00, 12'h004, Z,       12'h005, 2'b11, 2'b00, 0, 16'd1);
        tbl[16] = mk(1, 0, 0, Z,       Z,       0, 1, 2'b10, 12'h004, Z,       12'h005, 2'b11, 2'b10, 1, 16'd1);
        tbl[17] = mk(0, 1, 1, 12'h002, Z,       1, 1, 2'b11, Z,       Z,       Z,       2'b00, 2'b00, 0, 16'd0);
        tbl[18] = mk(1, 0, 0, 12'h004, Z,       0, 0, 2'b00, 12'h004, Z,       Z,       2'b00, 2'b00, 0, 16'd0);

        for (int k = 0; k < NV; k++) begin
            apply(tbl[k]);
            check($sformatf("vec%0d new_data", k), 64'(bus.new_data_o), 64'(tbl[k].e_new));
            check($sformatf("vec%0d missed", k), 64'(bus.missed_o),
                  64'(tbl[k].e_missed & {NCH{MISSED_ON}}));
            check($sformatf("vec%0d snap", k), 64'(bus.snap_new_data_o), 64'(tbl[k].e_snap));
            check($sformatf("vec%0d status", k), 64'(bus.status_o), 64'(tbl[k].e_status));
            check($sformatf("vec%0d irq_en", k), 64'(bus.irq_en_o), 64'(tbl[k].e_en));
            check($sformatf("vec%0d irq", k), 64'(bus.irq_o), 64'(tbl[k].e_irq));
            check($sformatf("vec%0d tic_cnt", k), 64'(bus.tic_cnt_o), 64'(tbl[k].e_cnt));
        end

        // TIC counter wrap: 65537 pulses from reset leave the count at 1.
        v = idle; v.rstn = 0;
        apply(v);
        v = idle; v.tic = 1;
        for (int k = 0; k < 65535; k++) apply(v);
        check("tic_cnt_at_ffff", 64'(bus.tic_cnt_o), 64'hFFFF);
        apply(v);
        check("tic_cnt_wrap0", 64'(bus.tic_cnt_o), 64'h0);
        apply(v);
        check("tic_cnt_wrap1", 64'(bus.tic_cnt_o), 64'h1);
        check("tic_flag_after_wrap", 64'(bus.status_o), 64'h2);
        check("irq_disabled_after_wrap", 64'(bus.irq_o), 64'h0);

        // Reset mid-stream with every strobe active.
        v = idle; v.rstn = 0; v.tic = 1; v.acc = 1; v.dump = '1; v.we = 1; v.wd = 2'b11;
        apply(v);
        check("midrst tic_cnt", 64'(bus.tic_cnt_o), 64'h0);
        check("midrst status", 64'(bus.status_o), 64'h0);
        check("midrst new_data", 64'(bus.new_data_o), 64'h0);
        check("midrst snap", 64'(bus.snap_new_data_o), 64'h0);
        check("midrst irq_en", 64'(bus.irq_en_o), 64'h0);
        check("midrst irq", 64'(bus.irq_o), 64'h0);
        check("midrst missed", 64'(bus.missed_o), 64'h0);

        // Randomized traffic against the behavioural model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v = idle;
            v.rstn  = ($urandom_range(0, 199) != 0);
            v.acc   = ($urandom_range(0, 7) == 0);
            v.tic   = ($urandom_range(0, 3) == 0);
            v.dump  = NCH'($urandom) & NCH'($urandom);
            v.ch_rd = NCH'($urandom) & NCH'($urandom);
            v.srd   = ($urandom_range(0, 5) == 0);
            v.we    = ($urandom_range(0, 15) == 0);
            v.wd    = 2'($urandom);
            apply(v);
            check_model(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
